boot_seq_ctrl: RTL and testbench
================================

// Module: boot_seq_ctrl
// PURPOSE
//  Bring-up sequencer for the mipse core. After reset it holds the core in reset, loads a
//  program from a byte stream into instruction memory, then releases the core and waits for
//  finish. It then streams a data-memory result window back out and reports completion.
//  Sits between the host byte link (UART rx/tx FIFOs), imem/dmem spare ports and core rst_n.
// PARAMETERS
//  IMEM_AW     8         imem word-address width; capacity 2**IMEM_AW words
//  DMEM_AW     8         dmem word-address width
//  DUMP_BASE   0         first dmem word address dumped after finish
//  DUMP_WORDS  16        number of dmem words dumped (1..2**DMEM_AW)
//  TIMEOUT     1000000   max core run cycles before watchdog error (32-bit counter)
// PORTS
//  clk          in   1        clock
//  rst_n        in   1        async active-low reset
//  rx_valid     in   1        host byte available
//  rx_data      in   8        host byte
//  rx_ready     out  1        byte consumed this cycle when rx_valid&rx_ready
//  imem_we      out  1        imem write strobe (one cycle per word)
//  imem_addr    out  IMEM_AW  imem word address
//  imem_wdata   out  32       imem word
//  core_rst_n   out  1        core reset, active-low
//  core_finish  in   1        core finish flag
//  dmem_addr    out  DMEM_AW  dmem word address (sync read, data valid next cycle)
//  dmem_rdata   in   32       dmem read data
//  tx_valid     out  1        result byte valid
//  tx_data      out  8        result byte
//  tx_ready     in   1        sink accepts byte when tx_valid&tx_ready
//  done         out  1        sequence completed OK (sticky until reset)
//  err          out  1        length overflow or watchdog timeout (sticky until reset)
//  run_cycles   out  32       core cycles counted in RUN; frozen afterwards
// BEHAVIOUR
//  Reset: state LEN_HI; rx_ready=0 during reset, all other outputs 0 (core_rst_n=0).
//  States: LEN_HI -> LEN_LO -> LOAD -> RUN -> DUMP_RD -> DUMP_TX -> DONE; any -> ERR.
//  - LEN_HI/LEN_LO: rx_ready=1; accept 16-bit word count N big-endian, one byte per handshake.
//    N > 2**IMEM_AW -> ERR. N == 0 -> RUN directly (imem untouched).
//  - LOAD: rx_ready=1; bytes packed big-endian (first byte -> [31:24]); on 4th byte assert
//    imem_we for exactly that cycle with imem_addr = word index (0..N-1), imem_wdata = word.
//    After word N-1 written, next cycle -> RUN. rx_ready=0 outside LEN_HI/LEN_LO/LOAD.
//  - RUN: core_rst_n=1 from first RUN cycle; run_cycles +1 per RUN cycle (saturates at
//    2**32-1). core_finish sampled high -> core_rst_n stays 1 (core holds own pc), go DUMP_RD;
//    run_cycles frozen. run_cycles reaching TIMEOUT with no finish -> ERR, core_rst_n=0.
//  - DUMP_RD: dmem_addr = DUMP_BASE+k (wraps mod 2**DMEM_AW); 1 cycle, then DUMP_TX.
//  - DUMP_TX: latch dmem_rdata on entry; emit 4 bytes MSB first; tx_valid held with stable
//    tx_data until tx_ready; after 4th accepted byte k+1 -> DUMP_RD, or DONE if k+1==DUMP_WORDS.
//  - DONE: done=1, tx_valid=0, core_rst_n stays 1. ERR: err=1, core_rst_n=0, no handshakes.
//  - rx bytes arriving in RUN/DUMP/DONE/ERR are not consumed (rx_ready=0).
//  - rst_n asserted mid-sequence: immediate return to reset state; partial word discarded.
// TESTING
//  1 N=2, bytes 00 02 3C 08 00 05 20 09 00 07 -> imem_we twice: addr0=3C080005, addr1=20090007,
//    then core_rst_n rises in the cycle after second write.
//  2 N=0x0101 with IMEM_AW=8 -> err=1 after LEN_LO byte, core_rst_n stays 0, rx_ready=0.
//  3 Finish after 50 RUN cycles, DUMP_WORDS=2, dmem[0]=11223344, dmem[1]=A5A5A5A5 ->
//    tx bytes 11 22 33 44 A5 A5 A5 A5, done=1, run_cycles=50.
//  4 tx_ready held low 10 cycles mid-dump -> tx_data/tx_valid stable, no byte lost or repeated.
//  5 TIMEOUT=100, finish never asserted -> err=1 at run_cycles=100, core_rst_n=0.
//  6 rst_n pulsed low during LOAD after 2 bytes of a word -> restart at LEN_HI, no imem_we.

Source files
------------

// File: rtl/boot_seq_ctrl_if.sv
// Host-link, memory-port and core-control signals of the bring-up sequencer.
// The sequencer takes the master side; the link, memories and core sit on the slave side.
interface boot_seq_ctrl_if #(
    parameter int unsigned IMEM_AW = 8,
    parameter int unsigned DMEM_AW = 8
);
    logic               rx_valid;
    logic [7:0]         rx_data;
    logic               rx_ready;
    logic               imem_we;
    logic [IMEM_AW-1:0] imem_addr;
    logic [31:0]        imem_wdata;
    logic               core_rst_n;
    logic               core_finish;
    logic [DMEM_AW-1:0] dmem_addr;
    logic [31:0]        dmem_rdata;
    logic               tx_valid;
    logic [7:0]         tx_data;
    logic               tx_ready;

    modport master (
        input  rx_valid, rx_data, core_finish, dmem_rdata, tx_ready,
        output rx_ready, imem_we, imem_addr, imem_wdata, core_rst_n,
               dmem_addr, tx_valid, tx_data
    );

    modport slave (
        output rx_valid, rx_data, core_finish, dmem_rdata, tx_ready,
        input  rx_ready, imem_we, imem_addr, imem_wdata, core_rst_n,
               dmem_addr, tx_valid, tx_data
    );
endinterface

// File: rtl/boot_seq_ctrl.sv
// Bring-up sequencer: loads a length-prefixed program into imem, runs the core under a
// watchdog, then streams a dmem window out byte-wise MSB first.
module boot_seq_ctrl #(
    parameter int unsigned IMEM_AW    = 8,
    parameter int unsigned DMEM_AW    = 8,
    parameter int unsigned DUMP_BASE  = 0,
    parameter int unsigned DUMP_WORDS = 16,
    parameter logic [31:0] TIMEOUT    = 32'd1000000
) (
    input  logic            clk,
    input  logic            rst_n,
    boot_seq_ctrl_if.master bus,
    output logic            done,
    output logic            err,
    output logic [31:0]     run_cycles
);
    typedef enum logic [2:0] {
        S_LEN_HI, S_LEN_LO, S_LOAD, S_RUN, S_DUMP_RD, S_DUMP_TX, S_DONE, S_ERR
    } state_t;

    localparam logic [32:0]        IMEM_CAP  = 33'(1) << IMEM_AW;
    localparam logic [DMEM_AW:0]   LAST_WORD = (DMEM_AW+1)'(DUMP_WORDS - 1);
    localparam logic [DMEM_AW-1:0] BASE      = DMEM_AW'(DUMP_BASE);

    state_t           state_q, state_d;
    logic [15:0]      len_q, len_d;
    logic [15:0]      widx_q, widx_d;
    logic [23:0]      word_q, word_d;
    logic [1:0]       byte_cnt_q, byte_cnt_d;
    logic [31:0]      run_q, run_d;
    logic [DMEM_AW:0] wcnt_q, wcnt_d;
    logic [31:0]      shift_q, shift_d;
    logic             lat_q, lat_d;
    logic             rx_fire;

    // rx_ready is gated by rst_n so the link sees no acceptance while reset is held
    assign bus.rx_ready   = rst_n & (state_q inside {S_LEN_HI, S_LEN_LO, S_LOAD});
    assign rx_fire        = bus.rx_valid & bus.rx_ready;
    assign bus.imem_we    = (state_q == S_LOAD) & rx_fire & (byte_cnt_q == 2'd3);
    assign bus.imem_addr  = IMEM_AW'(widx_q);
    assign bus.imem_wdata = bus.imem_we ? {word_q, bus.rx_data} : '0;
    assign bus.core_rst_n = state_q inside {S_RUN, S_DUMP_RD, S_DUMP_TX, S_DONE};
    assign bus.dmem_addr  = (state_q inside {S_DUMP_RD, S_DUMP_TX}) ?
                            BASE + DMEM_AW'(wcnt_q) : '0;
    assign bus.tx_valid   = (state_q == S_DUMP_TX) & lat_q;
    assign bus.tx_data    = bus.tx_valid ? shift_q[31:24] : '0;
    assign done           = (state_q == S_DONE);
    assign err            = (state_q == S_ERR);
    assign run_cycles     = run_q;

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        widx_d     = widx_q;
        word_d     = word_q;
        byte_cnt_d = byte_cnt_q;
        run_d      = run_q;
        wcnt_d     = wcnt_q;
        shift_d    = shift_q;
        lat_d      = lat_q;
        unique case (state_q)
            S_LEN_HI: if (rx_fire) begin
                len_d[15:8] = bus.rx_data;
                state_d     = S_LEN_LO;
            end
            S_LEN_LO: if (rx_fire) begin
                len_d      = {len_q[15:8], bus.rx_data};
                widx_d     = '0;
                byte_cnt_d = '0;
                word_d     = '0;
                if ({17'd0, len_d} > IMEM_CAP) state_d = S_ERR;
                else if (len_d == 16'd0)       state_d = S_RUN;
                else                           state_d = S_LOAD;
            end
            S_LOAD: if (rx_fire) begin
                word_d     = {word_q[15:0], bus.rx_data};
                byte_cnt_d = byte_cnt_q + 2'd1;
                if (byte_cnt_q == 2'd3) begin
                    widx_d = widx_q + 16'd1;
                    if (widx_d == len_q) state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (bus.core_finish) begin
                    wcnt_d  = '0;
                    state_d = S_DUMP_RD;
                end else begin
                    if (run_q != '1) run_d = run_q + 32'd1;
                    if (run_d >= TIMEOUT) state_d = S_ERR;
                end
            end
            S_DUMP_RD: begin
                byte_cnt_d = '0;
                lat_d      = 1'b0;
                state_d    = S_DUMP_TX;
            end
            // first DUMP_TX cycle captures the sync-read word; bytes go out from then on
            S_DUMP_TX: begin
                if (!lat_q) begin
                    shift_d = bus.dmem_rdata;
                    lat_d   = 1'b1;
                end else if (bus.tx_ready) begin
                    shift_d    = {shift_q[23:0], 8'h00};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        if (wcnt_q == LAST_WORD) begin
                            state_d = S_DONE;
                        end else begin
                            wcnt_d  = wcnt_q + (DMEM_AW+1)'(1);
                            state_d = S_DUMP_RD;
                        end
                    end
                end
            end
            S_DONE: ;
            S_ERR:  ;
            default: state_d = S_ERR;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_LEN_HI;
            len_q      <= '0;
            widx_q     <= '0;
            word_q     <= '0;
            byte_cnt_q <= '0;
            run_q      <= '0;
            wcnt_q     <= '0;
            shift_q    <= '0;
            lat_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            widx_q     <= widx_d;
            word_q     <= word_d;
            byte_cnt_q <= byte_cnt_d;
            run_q      <= run_d;
            wcnt_q     <= wcnt_d;
            shift_q    <= shift_d;
            lat_q      <= lat_d;
        end
    end
endmodule

// File: tb/tb_boot_seq_ctrl.sv
// Scoreboard bench for boot_seq_ctrl: expected imem writes and tx bytes are queued from the
// program/dmem contents, and a monitor pops and compares them as the DUT presents them.
module tb_boot_seq_ctrl;
    localparam int unsigned IMEM_AW    = 8;
    localparam int unsigned DMEM_AW    = 8;
    localparam int unsigned DUMP_BASE  = 254;
    localparam int unsigned DUMP_WORDS = 4;
    localparam int unsigned TIMEOUT    = 100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        done, err;
    logic [31:0] run_cycles;

    boot_seq_ctrl_if #(.IMEM_AW(IMEM_AW), .DMEM_AW(DMEM_AW)) bus ();

    boot_seq_ctrl #(
        .IMEM_AW   (IMEM_AW),
        .DMEM_AW   (DMEM_AW),
        .DUMP_BASE (DUMP_BASE),
        .DUMP_WORDS(DUMP_WORDS),
        .TIMEOUT   (32'(TIMEOUT))
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .done      (done),
        .err       (err),
        .run_cycles(run_cycles)
    );

    always #5 clk = ~clk;

    logic [31:0] dmem [256];
    always @(posedge clk) bus.dmem_rdata <= dmem[bus.dmem_addr];

    typedef struct {
        logic [7:0]  a;
        logic [31:0] d;
    } iw_t;

    int          vectors = 0;
    int          miscompares = 0;
    int          tx_seen = 0;
    iw_t         exp_imem[$];
    logic [7:0]  exp_tx[$];
    logic [31:0] prog[$];
    bit          stall_req = 1'b0;
    int          stall_left = 0;
    bit          stall_done = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    initial begin : monitor
        bit         prev_stall;
        logic [7:0] prev_data;
        iw_t        e;
        prev_stall = 1'b0;
        prev_data  = '0;
        forever begin
            @(negedge clk);
            if (prev_stall)
                chk("tx_hold", {bus.tx_valid, bus.tx_data}, {1'b1, prev_data});
            prev_stall = bus.tx_valid && !bus.tx_ready;
            prev_data  = bus.tx_data;
            if (bus.imem_we) begin
                if (exp_imem.size() == 0) begin
                    chk("imem_unexpected", bus.imem_we, 0);
                end else begin
                    e = exp_imem.pop_front();
                    chk("imem_addr", bus.imem_addr, e.a);
                    chk("imem_wdata", bus.imem_wdata, e.d);
                    chk("core_rst_n_in_load", bus.core_rst_n, 0);
                end
            end
            if (bus.tx_valid && bus.tx_ready) begin
                tx_seen++;
                if (exp_tx.size() == 0) chk("tx_unexpected", bus.tx_valid, 0);
                else                    chk("tx_byte", bus.tx_data, exp_tx.pop_front());
            end
        end
    end

    // Random sink backpressure, with one forced 10-cycle stall six bytes into a dump.
    initial begin : sink
        bus.tx_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (!stall_req) stall_done = 1'b0;
            if (stall_left > 0) begin
                bus.tx_ready = 1'b0;
                stall_left--;
            end else if (stall_req && !stall_done && bus.tx_valid && (tx_seen % 16 == 6)) begin
                stall_done   = 1'b1;
                stall_left   = 9;
                bus.tx_ready = 1'b0;
            end else begin
                bus.tx_ready = ($urandom_range(0, 3) != 0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step();
        rst_n = 1'b0;
        bus.rx_valid = 1'b1;
        bus.rx_data = 8'hA5;
        bus.core_finish = 1'b0;
        @(negedge clk);
        chk("reset_outputs", {bus.rx_ready, bus.core_rst_n, bus.tx_valid, bus.imem_we,
                              done, err, bus.dmem_addr, bus.imem_wdata}, 0);
        chk("reset_run_cycles", run_cycles, 0);
        step();
        step();
        rst_n = 1'b1;
        bus.rx_valid = 1'b0;
    endtask

    // Returns one posedge+1 after the accepting edge, with no trailing idle gap.
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        repeat ($urandom_range(0, 1)) step();
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.rx_ready && n < 40);
        if (!bus.rx_ready) chk("rx_accept_timeout", bus.rx_ready, 1);
        step();
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'($urandom);
    endtask

    task automatic load_prog(input int unsigned n);
        iw_t e;
        logic [31:0] w;
        send_byte(8'(n >> 8));
        send_byte(8'(n));
        for (int unsigned i = 0; i < n; i++) begin
            w = prog[i];
            e.a = 8'(i);
            e.d = w;
            exp_imem.push_back(e);
            send_byte(w[31:24]);
            send_byte(w[23:16]);
            send_byte(w[15:8]);
            send_byte(w[7:0]);
        end
    endtask

    task automatic run_dump(input int unsigned m, input bit stall);
        logic [31:0] w;
        int n;
        stall_req = stall;
        for (int unsigned k = 0; k < DUMP_WORDS; k++) begin
            w = dmem[8'(DUMP_BASE + k)];
            for (int j = 3; j >= 0; j--) exp_tx.push_back(w[8*j +: 8]);
        end
        chk("core_rst_n_rise", bus.core_rst_n, 1);
        chk("run_start", run_cycles, 0);
        repeat (m) @(posedge clk);
        #1;
        bus.core_finish = 1'b1;
        n = 0;
        while (!done && n < 600) begin
            @(negedge clk);
            n++;
        end
        chk("done", done, 1);
        chk("err_clear", err, 0);
        chk("run_cycles", run_cycles, m);
        chk("core_rst_n_done", bus.core_rst_n, 1);
        chk("rx_ready_done", bus.rx_ready, 0);
        chk("tx_valid_done", bus.tx_valid, 0);
        chk("tx_drained", exp_tx.size(), 0);
        chk("imem_drained", exp_imem.size(), 0);
        stall_req = 1'b0;
    endtask

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1, "watchdog");
    end

    initial begin : main
        int n;
        int unsigned nw;
        bus.rx_valid    = 1'b0;
        bus.rx_data     = '0;
        bus.core_finish = 1'b0;
        for (int i = 0; i < 256; i++) dmem[i] = $urandom;

        // Reference program, dump window at 254..1 wraps, backpressure stall mid-dump
        do_reset();
        dmem[254] = 32'h11223344;
        dmem[255] = 32'hA5A5A5A5;
        prog = '{32'h3C080005, 32'h20090007};
        load_prog(2);
        run_dump(50, 1'b1);

        // Word count one past capacity
        do_reset();
        send_byte(8'h01);
        send_byte(8'h01);
        chk("len_ovf_err", err, 1);
        chk("len_ovf_core_rst_n", bus.core_rst_n, 0);
        chk("len_ovf_rx_ready", bus.rx_ready, 0);
        bus.rx_valid = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("err_no_rx", bus.rx_ready, 0);
        end
        bus.rx_valid = 1'b0;

        // Exactly full capacity
        do_reset();
        prog = {};
        for (int i = 0; i < 256; i++) prog.push_back($urandom);
        load_prog(256);
        run_dump($urandom_range(0, 20), 1'b0);

        // Watchdog: finish never asserted
        do_reset();
        prog = '{32'hDEADBEEF};
        load_prog(1);
        chk("to_run_start", run_cycles, 0);
        n = 0;
        while (!err && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("to_err", err, 1);
        chk("to_run_cycles", run_cycles, TIMEOUT);
        chk("to_core_rst_n", bus.core_rst_n, 0);
        chk("to_done", done, 0);
        repeat (3) @(negedge clk);
        chk("to_frozen", run_cycles, TIMEOUT);

        // Reset in the middle of a word, then a clean one-word load
        do_reset();
        send_byte(8'h00);
        send_byte(8'h03);
        send_byte(8'h77);
        send_byte(8'h66);
        do_reset();
        prog = '{$urandom};
        load_prog(1);
        run_dump($urandom_range(0, 99), 1'b0);

        // Empty program, finish on the last cycle before the watchdog
        do_reset();
        load_prog(0);
        run_dump(TIMEOUT - 1, 1'b0);

        // Randomized programs, dump contents and run lengths
        for (int it = 0; it < 6; it++) begin
            do_reset();
            for (int unsigned k = 0; k < DUMP_WORDS; k++) dmem[8'(DUMP_BASE + k)] = $urandom;
            nw = $urandom_range(0, 6);
            prog = {};
            for (int unsigned i = 0; i < nw; i++) prog.push_back($urandom);
            load_prog(nw);
            run_dump($urandom_range(0, 99), it == 2);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
